// File: rtl/mem_frame_reader_pkg.sv
// Shared definitions for the pixel-memory read initiator: memory command
// encodings, controller states and default geometry.
package mem_frame_reader_pkg;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH      = 262144;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_ERROR
    } rdr_state_t;

endpackage

// File: rtl/mem_frame_reader_fifo.sv
// Small synchronous FIFO holding fetched pixels plus their end-of-run bit.
// Flush empties it in one cycle; the head word is always presented on o_data.
module mem_rdr_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            if (w_doPush && !w_doPop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_doPush && w_doPop) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointers alone decide what is visible.
    always_ff @(posedge i_clk) begin
        if (w_doPush && !i_flush && !i_reset) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/mem_frame_reader.sv
// Fetches a run of pixels from the pixel memory, one read at a time, and
// streams them out through a small FIFO with an end-of-run marker.
module mem_frame_reader
    import mem_frame_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_WIDTH  = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  Rdr_CLK,
    input  logic                  Rdr_RST,
    input  logic                  Rdr_START,
    input  logic [ADDR_WIDTH-1:0] Rdr_BASE,
    input  logic [CNT_WIDTH-1:0]  Rdr_COUNT,
    output logic                  Rdr_BUSY,
    output logic                  Rdr_DONE,
    output logic                  Rdr_ERR,
    output logic [1:0]            Mem_RW,
    output logic [ADDR_WIDTH-1:0] Mem_ADDR,
    output logic [DATA_WIDTH-1:0] Mem_IDR,
    input  logic [DATA_WIDTH-1:0] Mem_ODR,
    input  logic                  Mem_DRDY,
    output logic [DATA_WIDTH-1:0] Pix_DATA,
    output logic                  Pix_VALID,
    input  logic                  Pix_READY,
    output logic                  Pix_LAST
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    rdr_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [CNT_WIDTH-1:0]  r_remain;
    logic [TW-1:0]         r_tmo;
    logic [1:0]            r_rw;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_timeout;
    logic                  w_full;
    logic                  w_empty;
    logic [FCW-1:0]        w_count;
    logic [DATA_WIDTH:0]   w_head;
    logic [DATA_WIDTH:0]   w_pushData;
    logic [ADDR_WIDTH-1:0] w_nextAddr;

    assign w_pushData = {(r_remain == CNT_WIDTH'(1)), Mem_ODR};
    assign w_push     = (r_state == ST_WAIT) && Mem_DRDY && !w_full;
    assign w_timeout  = (r_state == ST_WAIT) && !Mem_DRDY && (r_tmo == TW'(TIMEOUT - 1));
    assign w_pop      = Pix_READY && !w_empty;
    assign w_nextAddr = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

    mem_rdr_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Rdr_CLK),
        .i_reset (Rdr_RST),
        .i_flush (w_timeout),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge Rdr_CLK) begin
        if (Rdr_RST) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_memAddr <= '0;
            r_remain  <= '0;
            r_tmo     <= '0;
            r_rw      <= RW_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (Rdr_START) begin
                        r_err <= 1'b0;
                        if (Rdr_COUNT == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_addr   <= Rdr_BASE;
                            r_remain <= Rdr_COUNT;
                            r_busy   <= 1'b1;
                            r_state  <= ST_ISSUE;
                        end
                    end
                end
                // A read is only launched once a FIFO slot is guaranteed.
                ST_ISSUE: begin
                    if (w_count < FCW'(FIFO_DEPTH)) begin
                        r_rw      <= RW_READ;
                        r_memAddr <= r_addr;
                        r_tmo     <= '0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_rw <= RW_IDLE;
                    if (w_push) begin
                        r_addr   <= w_nextAddr;
                        r_remain <= r_remain - CNT_WIDTH'(1);
                        r_state  <= (r_remain == CNT_WIDTH'(1)) ? ST_DRAIN : ST_ISSUE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_ERROR;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Rdr_BUSY  = r_busy;
    assign Rdr_DONE  = r_done;
    assign Rdr_ERR   = r_err;
    assign Mem_RW    = r_rw;
    assign Mem_ADDR  = r_memAddr;
    assign Mem_IDR   = '0;
    assign Pix_DATA  = w_head[DATA_WIDTH-1:0];
    assign Pix_VALID = !w_empty;
    assign Pix_LAST  = w_head[DATA_WIDTH] && !w_empty;

endmodule

// File: tb/tb_mem_frame_reader.sv
// Randomized bench for mem_frame_reader: a behavioural memory responder and a
// stream consumer compare every request and pixel with precomputed run lists.
module tb_mem_frame_reader;

    localparam int DW    = 24;
    localparam int AW    = 32;
    localparam int DEPTH = 262144;
    localparam int CW    = 19;
    localparam int FD    = 4;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          Rdr_RST = 1'b1;
    logic          Rdr_START = 1'b0;
    logic [AW-1:0] Rdr_BASE = '0;
    logic [CW-1:0] Rdr_COUNT = '0;
    logic          Rdr_BUSY;
    logic          Rdr_DONE;
    logic          Rdr_ERR;
    logic [1:0]    Mem_RW;
    logic [AW-1:0] Mem_ADDR;
    logic [DW-1:0] Mem_IDR;
    logic [DW-1:0] Mem_ODR = '0;
    logic          Mem_DRDY = 1'b0;
    logic [DW-1:0] Pix_DATA;
    logic          Pix_VALID;
    logic          Pix_READY = 1'b0;
    logic          Pix_LAST;

    mem_frame_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (FD),
        .TIMEOUT    (TMO)
    ) dut (
        .Rdr_CLK   (clk),
        .Rdr_RST   (Rdr_RST),
        .Rdr_START (Rdr_START),
        .Rdr_BASE  (Rdr_BASE),
        .Rdr_COUNT (Rdr_COUNT),
        .Rdr_BUSY  (Rdr_BUSY),
        .Rdr_DONE  (Rdr_DONE),
        .Rdr_ERR   (Rdr_ERR),
        .Mem_RW    (Mem_RW),
        .Mem_ADDR  (Mem_ADDR),
        .Mem_IDR   (Mem_IDR),
        .Mem_ODR   (Mem_ODR),
        .Mem_DRDY  (Mem_DRDY),
        .Pix_DATA  (Pix_DATA),
        .Pix_VALID (Pix_VALID),
        .Pix_READY (Pix_READY),
        .Pix_LAST  (Pix_LAST)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Memory contents: two fixed words at the bottom, a salted pattern elsewhere.
    logic [DW-1:0] memSalt = '0;

    function automatic logic [DW-1:0] pixelAt(input logic [AW-1:0] addr);
        logic [DW-1:0] mix;
        if (addr == 0) return 24'hAABBCC;
        if (addr == 1) return 24'h112233;
        mix = addr[DW-1:0] * 24'h0009E3;
        return mix ^ memSalt;
    endfunction

    logic [AW-1:0] expAddrQ[$];
    logic [DW:0]   expPixQ[$];

    int            memWait = 0;
    logic [AW-1:0] pendAddr = '0;
    int            reqCount = 0;
    int            withholdAt = 0;
    int            extraMax = 0;
    int            extraFixed = 0;
    int            badRw = 0;

    // Memory responder: answers each read after a (possibly extended) delay.
    always @(negedge clk) begin
        Mem_DRDY = 1'b0;
        Mem_ODR  = DW'($urandom);
        if (memWait > 0) begin
            memWait--;
            if (memWait == 0) begin
                Mem_DRDY = 1'b1;
                Mem_ODR  = pixelAt(pendAddr);
            end
        end
        if (Mem_RW == 2'b01 || Mem_RW == 2'b11) badRw++;
        if (Mem_RW == 2'b10) begin
            reqCount++;
            if (expAddrQ.size() > 0) checkOutput("req_addr", Mem_ADDR, expAddrQ.pop_front());
            else                     checkOutput("unexpected_req", 1, 0);
            if (reqCount != withholdAt) begin
                pendAddr = Mem_ADDR;
                memWait  = 1 + extraFixed + int'($urandom_range(extraMax, 0));
            end
        end
    end

    int          readyMode = 1;
    logic        stallHeld = 1'b0;
    logic [DW:0] heldPix = '0;
    int          pixCount = 0;

    // Stream consumer: checks stall stability and every accepted pixel.
    always @(negedge clk) begin
        logic [DW:0] exp;
        if (stallHeld && Pix_VALID) begin
            checkOutput("stall_data", Pix_DATA, heldPix[DW-1:0]);
            checkOutput("stall_last", Pix_LAST, heldPix[DW]);
        end
        case (readyMode)
            0:       Pix_READY = 1'b0;
            1:       Pix_READY = 1'b1;
            default: Pix_READY = 1'($urandom_range(1, 0));
        endcase
        stallHeld = Pix_VALID && !Pix_READY;
        heldPix   = {Pix_LAST, Pix_DATA};
        if (Pix_VALID && Pix_READY) begin
            pixCount++;
            if (expPixQ.size() > 0) begin
                exp = expPixQ.pop_front();
                checkOutput("pix_data", Pix_DATA, exp[DW-1:0]);
                checkOutput("pix_last", Pix_LAST, exp[DW]);
            end else begin
                checkOutput("extra_pixel", 1, 0);
            end
        end
    end

    int doneCount = 0;
    always @(negedge clk) if (Rdr_DONE) doneCount++;

    task automatic applyStimulus(input logic [AW-1:0] base, input int count);
        logic [AW-1:0] a;
        expAddrQ.delete();
        expPixQ.delete();
        reqCount  = 0;
        pixCount  = 0;
        doneCount = 0;
        badRw     = 0;
        for (int i = 0; i < count; i++) begin
            a = AW'((longint'(base) + longint'(i)) % DEPTH);
            expAddrQ.push_back(a);
            expPixQ.push_back({(i == count - 1), pixelAt(a)});
        end
        Rdr_BASE  = base;
        Rdr_COUNT = CW'(count);
        Rdr_START = 1'b1;
        @(negedge clk);
        Rdr_START = 1'b0;
        Rdr_BASE  = $urandom;
        Rdr_COUNT = CW'($urandom);
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (!Rdr_DONE && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, Rdr_DONE, 1);
    endtask

    task automatic finishRun(input string tag, input int expReq);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_reqs"}, reqCount, expReq);
        checkOutput({tag, "_pixels"}, pixCount, expReq);
        checkOutput({tag, "_done_count"}, doneCount, 1);
        checkOutput({tag, "_busy"}, Rdr_BUSY, 0);
        checkOutput({tag, "_bad_rw"}, badRw, 0);
        checkOutput({tag, "_left"}, expPixQ.size(), 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rw"}, Mem_RW, 0);
        checkOutput({tag, "_addr"}, Mem_ADDR, 0);
        checkOutput({tag, "_busy"}, Rdr_BUSY, 0);
        checkOutput({tag, "_done"}, Rdr_DONE, 0);
        checkOutput({tag, "_err"}, Rdr_ERR, 0);
        checkOutput({tag, "_valid"}, Pix_VALID, 0);
        checkOutput({tag, "_last"}, Pix_LAST, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        int   cyc;
        logic vSeen;
        logic [AW-1:0] base;

        repeat (3) @(negedge clk);
        checkReset("reset");
        Rdr_RST = 1'b0;
        @(negedge clk);

        // Two fixed words, minimum memory latency, consumer always ready.
        readyMode = 1;
        applyStimulus(0, 2);
        checkOutput("t1_busy", Rdr_BUSY, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t1_valid_early", Pix_VALID, 0);
        @(negedge clk);
        checkOutput("t1_latency_valid", Pix_VALID, 1);
        waitDone("t1", 100);
        finishRun("t1", 2);

        // Zero-length run: immediate DONE, no memory traffic, no pixels.
        applyStimulus($urandom_range(DEPTH - 1, 0), 0);
        checkOutput("t2_done", Rdr_DONE, 1);
        checkOutput("t2_busy", Rdr_BUSY, 0);
        vSeen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            vSeen |= Pix_VALID;
        end
        checkOutput("t2_valid", vSeen, 0);
        checkOutput("t2_reqs", reqCount, 0);
        checkOutput("t2_done_count", doneCount, 1);

        // Address wrap at the top of memory.
        memSalt = DW'($urandom);
        applyStimulus(DEPTH - 2, 4);
        waitDone("t3", 100);
        finishRun("t3", 4);

        // Stalled consumer: only FD reads may be outstanding in the buffer.
        readyMode = 0;
        applyStimulus($urandom_range(DEPTH - 1, 0), 8);
        repeat (40) @(negedge clk);
        checkOutput("t4_reqs_stalled", reqCount, FD);
        checkOutput("t4_rw_idle", Mem_RW, 0);
        checkOutput("t4_valid_stalled", Pix_VALID, 1);
        readyMode = 2;
        waitDone("t4", 500);
        finishRun("t4", 8);

        // Third read never answered: timeout, error, then recovery.
        readyMode  = 1;
        withholdAt = 3;
        applyStimulus($urandom_range(DEPTH - 1, 0), 5);
        n = 0;
        while (reqCount < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_third_req", reqCount, 3);
        cyc = 0;
        while (!Rdr_ERR && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t5_err", Rdr_ERR, 1);
        checkOutput("t5_timeout_window", (cyc >= TMO - 1 && cyc <= TMO), 1);
        checkOutput("t5_valid", Pix_VALID, 0);
        checkOutput("t5_busy", Rdr_BUSY, 0);
        checkOutput("t5_pixels", pixCount, 2);
        withholdAt = 0;
        @(negedge clk);
        applyStimulus($urandom_range(DEPTH - 1, 0), 3);
        checkOutput("t5_err_cleared", Rdr_ERR, 0);
        waitDone("t5", 100);
        finishRun("t5", 3);

        // Reset while waiting for data; the late response must be dropped.
        extraFixed = 3;
        applyStimulus($urandom_range(DEPTH - 1, 0), 3);
        n = 0;
        while (Mem_RW != 2'b10 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_req_seen", Mem_RW, 2'b10);
        Rdr_RST = 1'b1;
        @(negedge clk);
        checkReset("t6_reset");
        Rdr_RST = 1'b0;
        extraFixed = 0;
        vSeen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            vSeen |= Pix_VALID;
        end
        checkOutput("t6_no_pixel", vSeen, 0);
        applyStimulus($urandom_range(DEPTH - 1, 0), 4);
        waitDone("t6", 100);
        finishRun("t6", 4);

        // Random runs with variable memory latency, back-pressure and a
        // stray START while busy that must be ignored.
        extraMax = 2;
        for (int r = 0; r < 12; r++) begin
            memSalt   = DW'($urandom);
            readyMode = int'($urandom_range(2, 1));
            base = ($urandom_range(1, 0) == 1) ? AW'(DEPTH - int'($urandom_range(4, 1)))
                                                : AW'($urandom_range(DEPTH - 1, 0));
            applyStimulus(base, int'($urandom_range(10, 1)));
            @(negedge clk);
            Rdr_START = 1'b1;
            @(negedge clk);
            Rdr_START = 1'b0;
            waitDone("rand", 400);
            finishRun("rand", expAddrQ.size() + reqCount);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_frame_reader.md
Name: mem_frame_reader

Overview:
- Read initiator for the 24-bit pixel Memory. It fetches a run of pixels starting at a base address, using the Memory read protocol.
- Fetched pixels are buffered and presented as a valid/ready pixel stream with an end-of-run marker.
- Sits between the Memory block and downstream pixel-processing stages. It replaces testbench-driven reads in the integrated design.

Parameters:
- DATA_WIDTH, 24, pixel width; matches Memory data width.
- ADDR_WIDTH, 32, Memory address width.
- DEPTH, 262144 (512*512), Memory depth in words; address wrap point.
- CNT_WIDTH, 19, width of the pixel-count input (covers DEPTH).
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.
- TIMEOUT, 64, maximum cycles to wait for Mem_DRDY after a request.

Ports:
- Rdr_CLK  in  1  single clock, rising edge.
- Rdr_RST  in  1  synchronous, active-high reset.
- Rdr_START  in  1  one-cycle start pulse.
- Rdr_BASE  in  ADDR_WIDTH  first address; sampled on an accepted start.
- Rdr_COUNT  in  CNT_WIDTH  number of pixels; sampled on an accepted start.
- Rdr_BUSY  out  1  high from an accepted start until done or error.
- Rdr_DONE  out  1  one-cycle pulse at run completion.
- Rdr_ERR  out  1  sticky timeout flag.
- Mem_RW  out  2  00 idle, 10 read; 01/11 never driven.
- Mem_ADDR  out  ADDR_WIDTH  read address.
- Mem_IDR  out  DATA_WIDTH  tied to 0.
- Mem_ODR  in  DATA_WIDTH  read data; valid while Mem_DRDY is high.
- Mem_DRDY  in  1  read-data-ready strobe.
- Pix_DATA  out  DATA_WIDTH  stream data (FIFO head).
- Pix_VALID  out  1  stream valid.
- Pix_READY  in  1  downstream accept.
- Pix_LAST  out  1  marks the final pixel of the run.

Behaviour:
- Reset values:
  - State IDLE.
  - Mem_RW=00, Mem_ADDR=0.
  - Rdr_BUSY, Rdr_DONE, Rdr_ERR, Pix_VALID, Pix_LAST all 0.
  - FIFO empty; timeout counter 0.
  - Reset mid-run aborts the run immediately and discards buffered pixels. A later Mem_DRDY is ignored.
- FSM states: IDLE, ISSUE, WAIT, DRAIN, ERROR.
- IDLE:
  - Rdr_START with COUNT>0 latches BASE into the address and COUNT into the remaining count, then enters ISSUE with BUSY=1.
  - Rdr_START with COUNT==0 pulses DONE the next cycle; the block stays in IDLE and issues no memory access.
- ISSUE:
  - If FIFO occupancy < FIFO_DEPTH, drive Mem_RW=10 for exactly one cycle with Mem_ADDR = current address, then go to WAIT.
  - Otherwise hold Mem_RW=00 and stay in ISSUE.
- WAIT:
  - Mem_RW=00; Mem_ADDR is held stable.
  - On Mem_DRDY: push Mem_ODR into the FIFO with a last bit set when remaining==1. Then increment the address and decrement remaining.
  - After that push, go to DRAIN if remaining reaches 0, otherwise ISSUE.
  - The timeout counter runs in WAIT only. When it reaches TIMEOUT with no Mem_DRDY: go to ERROR, set ERR=1, flush the FIFO, clear BUSY.
- DRAIN:
  - Stay until the FIFO is empty and the last pixel has been accepted.
  - Then pulse DONE for one cycle, clear BUSY, go to IDLE.
- ERROR:
  - Mem_RW=00, Pix_VALID=0.
  - Rdr_START clears ERR and is handled exactly as in IDLE.
- Only one read is outstanding at a time. The FIFO slot is reserved before issue, so a push never meets a full FIFO.
- Address arithmetic: next = (addr == DEPTH-1) ? 0 : addr+1. Wrap is silent.
- Stream:
  - Pix_VALID = FIFO not empty.
  - A pop happens when VALID && READY. Pix_DATA and Pix_LAST must not change while VALID && !READY.
  - Simultaneous push and pop keeps occupancy unchanged; ordering is preserved.
- Mem_DRDY outside WAIT is ignored.
- Rdr_START while BUSY is ignored; latched base and count are unchanged.
- Minimum latency: start to first Pix_VALID is 3 cycles with Memory DRDY one cycle after the request.

Decomposition:
- Shared package holds:
  - Mem_RW encodings RW_IDLE=2'b00, RW_WRITE=2'b01, RW_READ=2'b10.
  - The FSM state enum.
  - DATA_WIDTH, ADDR_WIDTH and DEPTH defaults.
- One sub-module, mem_rdr_fifo: synchronous FIFO of width DATA_WIDTH+1 (data plus last bit), depth FIFO_DEPTH, with push/pop/full/empty/count outputs.

Test Plan:
- Memory preloaded with 0:AABBCC and 1:112233; start BASE=0, COUNT=2, READY=1 -> two Mem_RW=10 requests at addresses 0 and 1. Stream delivers AABBCC then 112233, with LAST on the second pixel; DONE pulses once and BUSY falls.
- COUNT=0 start -> no Mem_RW=10 is ever driven; DONE pulses within 1 cycle; Pix_VALID stays 0.
- BASE=DEPTH-2, COUNT=4, READY=1 -> requested addresses are 262142, 262143, 0, 1, in order; LAST on the 4th pixel.
- COUNT=8, READY held 0 -> exactly FIFO_DEPTH (4) reads issued, then Mem_RW stays 00. Releasing READY delivers all 8 pixels in order, with data stable during the stall.
- Memory model withholds DRDY on the 3rd read -> ERR=1 after 64 WAIT cycles; Pix_VALID=0 and BUSY=0. A new START clears ERR and completes normally.
- RST asserted while in WAIT -> all outputs at reset values the next cycle. A late DRDY produces no pixel, and a fresh run then works.
